imem_fetch_port: RTL and testbench

Parametrised, synchronous instruction memory with a valid/ready fetch interface, alignment/range fault reporting, a program-load write port and a pipeline flush. It sits between the RISC-V fetch stage and on-chip block RAM. On the FPGA build, the UART/JTAG loader uses the load port to fill program contents at run time instead of baking them in at synthesis.

---
 rtl/imem_fetch_port_if.sv | 35 +++
 rtl/imem_fetch_port.sv | 113 +++++++++++
 tb/tb_imem_fetch_port.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_port_if.sv
// Fetch/response handshake, load port and flush bundled between the fetch stage
// and the instruction memory. The memory side uses the slave modport.
interface imem_fetch_port_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
);
    localparam int AW = $clog2(DEPTH);

    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_pc;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_instr;
    logic [31:0]       resp_pc;
    logic [1:0]        resp_fault;

    logic              flush;

    logic              ld_en;
    logic [AW:0]       ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_err;

    modport master (
        output req_valid, req_pc, resp_ready, flush, ld_en, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_instr, resp_pc, resp_fault, ld_err
    );

    modport slave (
        input  req_valid, req_pc, resp_ready, flush, ld_en, ld_addr, ld_data,
        output req_ready, resp_valid, resp_instr, resp_pc, resp_fault, ld_err
    );
endinterface

// File: rtl/imem_fetch_port.sv
// Synchronous instruction memory behind a valid/ready fetch port, with fault
// reporting, a run-time program-load port and a pipeline flush.
module imem_fetch_port #(
    parameter int              DATA_W    = 32,
    parameter int              DEPTH     = 256,
    parameter string           INIT_FILE = "",
    parameter logic [DATA_W-1:0] NOP     = DATA_W'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst_n,
    imem_fetch_port_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              misaligned;
    logic              outOfRange;
    fault_e            reqFault;
    logic [AW-1:0]     rdIdx;
    logic              reqReady;
    logic              accept;
    logic              ldInRange;
    logic              ldWrite;

    logic              respValid_q, respValid_d;
    logic [31:0]       respPc_q,    respPc_d;
    fault_e            respFault_q, respFault_d;
    logic              useNop_q,    useNop_d;
    logic              ldErr_q,     ldErr_d;
    logic [DATA_W-1:0] rdata_q;

    // A pending load blocks fetches, so the RAM never sees read and write together.
    always_comb begin
        misaligned = |bus.req_pc[1:0];
        outOfRange = ({2'b00, bus.req_pc[31:2]} >= 32'(DEPTH));
        if (misaligned) begin
            reqFault = FAULT_MISALIGN;
        end else if (outOfRange) begin
            reqFault = FAULT_RANGE;
        end else begin
            reqFault = FAULT_OK;
        end
        rdIdx     = bus.req_pc[AW+1:2];
        reqReady  = !bus.ld_en && !bus.flush && (!respValid_q || bus.resp_ready);
        accept    = bus.req_valid && reqReady;
        ldInRange = !bus.ld_addr[AW];
        ldWrite   = bus.ld_en && ldInRange;
    end

    always_comb begin
        respValid_d = respValid_q;
        respPc_d    = respPc_q;
        respFault_d = respFault_q;
        useNop_d    = useNop_q;
        ldErr_d     = ldErr_q | (bus.ld_en && !ldInRange);

        if (bus.flush) begin
            respValid_d = 1'b0;
        end else if (accept) begin
            respValid_d = 1'b1;
            respPc_d    = bus.req_pc;
            respFault_d = reqFault;
            useNop_d    = (reqFault != FAULT_OK);
        end else if (respValid_q && bus.resp_ready) begin
            respValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            respValid_q <= 1'b0;
            respPc_q    <= '0;
            respFault_q <= FAULT_OK;
            useNop_q    <= 1'b1;
            ldErr_q     <= 1'b0;
        end else begin
            respValid_q <= respValid_d;
            respPc_q    <= respPc_d;
            respFault_q <= respFault_d;
            useNop_q    <= useNop_d;
            ldErr_q     <= ldErr_d;
        end
    end

    // RAM and its read register carry no reset so they map onto block RAM;
    // useNop_q masks the read data until a clean fetch has completed.
    always_ff @(posedge clk) begin
        if (ldWrite) begin
            mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (reqFault == FAULT_OK)) begin
            rdata_q <= mem[rdIdx];
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.resp_valid = respValid_q;
    assign bus.resp_instr = useNop_q ? NOP : rdata_q;
    assign bus.resp_pc    = respPc_q;
    assign bus.resp_fault = respFault_q;
    assign bus.ld_err     = ldErr_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed and randomized checks of imem_fetch_port against a transaction-level
// reference model (word array plus one pending-response slot).
module tb_imem_fetch_port;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 256;
    localparam int          AW     = 8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    imem_fetch_port_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    imem_fetch_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_FILE(""),
        .NOP      (NOP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] refMem [DEPTH];
    bit          mValid;
    logic [31:0] mInstr;
    logic [31:0] mPc;
    logic [1:0]  mFault;
    bit          mLdErr;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit rv, input logic [31:0] pc, input bit rr, input bit fl,
                                 input bit le, input logic [AW:0] la, input logic [31:0] ld);
        bus.req_valid  = rv;
        bus.req_pc     = pc;
        bus.resp_ready = rr;
        bus.flush      = fl;
        bus.ld_en      = le;
        bus.ld_addr    = la;
        bus.ld_data    = ld;
    endtask

    task automatic modelReset();
        mValid = 0;
        mInstr = NOP;
        mPc    = 32'h0;
        mFault = 2'b00;
        mLdErr = 0;
    endtask

    // One clock: check the ready decision, advance the model, then check all outputs.
    task automatic tick(input string tag);
        bit          expReady;
        bit          take;
        logic [31:0] pc;
        #1;
        expReady = !bus.ld_en && !bus.flush && (!mValid || bus.resp_ready);
        checkOutput({tag, ".req_ready"}, {63'd0, bus.req_ready}, {63'd0, expReady});
        take = bus.req_valid && expReady;
        pc   = bus.req_pc;
        if (bus.flush) begin
            mValid = 0;
        end else if (take) begin
            mValid = 1;
            mPc    = pc;
            if (pc[1:0] != 2'b00) begin
                mFault = 2'b01;
                mInstr = NOP;
            end else if (pc >= 32'(4 * DEPTH)) begin
                mFault = 2'b10;
                mInstr = NOP;
            end else begin
                mFault = 2'b00;
                mInstr = refMem[pc / 4];
            end
        end else if (mValid && bus.resp_ready) begin
            mValid = 0;
        end
        if (bus.ld_en) begin
            if (int'(bus.ld_addr) < DEPTH) refMem[int'(bus.ld_addr)] = bus.ld_data;
            else mLdErr = 1;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".resp_valid"}, {63'd0, bus.resp_valid}, {63'd0, mValid});
        checkOutput({tag, ".resp_instr"}, {32'd0, bus.resp_instr}, {32'd0, mInstr});
        checkOutput({tag, ".resp_pc"},    {32'd0, bus.resp_pc},    {32'd0, mPc});
        checkOutput({tag, ".resp_fault"}, {62'd0, bus.resp_fault}, {62'd0, mFault});
        checkOutput({tag, ".ld_err"},     {63'd0, bus.ld_err},     {63'd0, mLdErr});
    endtask

    initial begin
        logic [31:0] heldInstr;
        logic [31:0] heldPc;
        logic [31:0] pc;
        int          r;

        applyStimulus(0, 32'h0, 1, 0, 0, '0, 32'h0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        checkOutput("reset.resp_instr", {32'd0, bus.resp_instr}, {32'd0, NOP});
        checkOutput("reset.resp_pc",    {32'd0, bus.resp_pc},    64'd0);
        checkOutput("reset.resp_fault", {62'd0, bus.resp_fault}, 64'd0);
        checkOutput("reset.ld_err",     {63'd0, bus.ld_err},     64'd0);
        checkOutput("reset.req_ready",  {63'd0, bus.req_ready},  64'd1);
        rst_n = 1'b1;

        $display("[TB] loading program words");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 32'h0, 1, 0, 1, (AW+1)'(i), $urandom());
            tick("load");
        end

        applyStimulus(1, 32'h0, 1, 0, 0, '0, 32'h0);
        tick("b2b0");
        checkOutput("b2b0.pc", {32'd0, bus.resp_pc}, 64'h0);
        applyStimulus(1, 32'h4, 1, 0, 0, '0, 32'h0);
        tick("b2b1");
        checkOutput("b2b1.pc", {32'd0, bus.resp_pc}, 64'h4);
        applyStimulus(1, 32'h8, 1, 0, 0, '0, 32'h0);
        tick("b2b2");
        checkOutput("b2b2.pc", {32'd0, bus.resp_pc}, 64'h8);

        applyStimulus(1, 32'h6, 1, 0, 0, '0, 32'h0);
        tick("misalign");
        checkOutput("misalign.instr", {32'd0, bus.resp_instr}, 64'h0000_0013);
        checkOutput("misalign.fault", {62'd0, bus.resp_fault}, 64'd1);
        applyStimulus(1, 32'h400, 1, 0, 0, '0, 32'h0);
        tick("range");
        checkOutput("range.instr", {32'd0, bus.resp_instr}, 64'h0000_0013);
        checkOutput("range.fault", {62'd0, bus.resp_fault}, 64'd2);
        applyStimulus(0, 32'h0, 1, 0, 0, '0, 32'h0);
        tick("drain0");

        applyStimulus(1, 32'h4, 1, 0, 0, '0, 32'h0);
        tick("stallAcc");
        heldInstr = bus.resp_instr;
        heldPc    = bus.resp_pc;
        applyStimulus(1, 32'h8, 0, 0, 0, '0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick("stall");
            checkOutput("stall.ready0", {63'd0, bus.req_ready}, 64'd0);
            checkOutput("stall.instr", {32'd0, bus.resp_instr}, {32'd0, heldInstr});
            checkOutput("stall.pc", {32'd0, bus.resp_pc}, {32'd0, heldPc});
        end
        applyStimulus(1, 32'h8, 1, 0, 0, '0, 32'h0);
        tick("release");
        checkOutput("release.pc", {32'd0, bus.resp_pc}, 64'h8);
        applyStimulus(0, 32'h0, 1, 0, 0, '0, 32'h0);
        tick("drain1");

        applyStimulus(1, 32'hC, 1, 0, 1, (AW+1)'(3), 32'hDEAD_BEEF);
        tick("ldBlock");
        applyStimulus(1, 32'hC, 1, 0, 0, '0, 32'h0);
        tick("ldRead");
        checkOutput("ldRead.instr", {32'd0, bus.resp_instr}, 64'hDEAD_BEEF);
        applyStimulus(0, 32'h0, 1, 0, 1, (AW+1)'(DEPTH), 32'hFFFF_FFFF);
        tick("ldErr");
        checkOutput("ldErr.flag", {63'd0, bus.ld_err}, 64'd1);
        applyStimulus(1, 32'h0, 1, 0, 0, '0, 32'h0);
        tick("ldErrRead0");
        applyStimulus(1, 32'hC, 1, 0, 0, '0, 32'h0);
        tick("ldErrRead3");
        checkOutput("ldErrRead3.instr", {32'd0, bus.resp_instr}, 64'hDEAD_BEEF);

        applyStimulus(1, 32'h10, 0, 0, 0, '0, 32'h0);
        tick("flushPend");
        applyStimulus(1, 32'h14, 0, 1, 0, '0, 32'h0);
        tick("flush");
        checkOutput("flush.valid", {63'd0, bus.resp_valid}, 64'd0);
        applyStimulus(0, 32'h0, 1, 0, 0, '0, 32'h0);
        tick("flushAfter");
        checkOutput("flushAfter.valid", {63'd0, bus.resp_valid}, 64'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) pc = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            else if (r == 7) pc = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
            else pc = $urandom() | 32'h0000_0400;
            applyStimulus($urandom_range(0, 3) != 0, pc, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                          (AW+1)'($urandom_range(0, DEPTH + 3)), $urandom());
            tick("rand");
        end

        applyStimulus(1, 32'h10, 1, 0, 0, '0, 32'h0);
        tick("rstAcc");
        applyStimulus(1, 32'h14, 0, 0, 0, '0, 32'h0);
        tick("rstStall");
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRst.valid", {63'd0, bus.resp_valid}, 64'd0);
        checkOutput("asyncRst.ld_err", {63'd0, bus.ld_err}, 64'd0);
        checkOutput("asyncRst.instr", {32'd0, bus.resp_instr}, {32'd0, NOP});
        modelReset();
        applyStimulus(0, 32'h0, 1, 0, 0, '0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 32'(i * 4), 1, 0, 0, '0, 32'h0);
            tick("postRst");
        end
        applyStimulus(0, 32'h0, 1, 0, 0, '0, 32'h0);
        tick("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
